mulhalfprecision_iter: RTL and testbench

- Multi-cycle IEEE-754 half-precision multiplier. It is the inverse-direction companion of the pipeline's combinational half-precision divider.
- It uses an iterative shift-add mantissa multiply under a start/done handshake.
- It sits in the pipeline arithmetic modules and feeds the same consumers as the divider: transform/scale stages.

---
 rtl/fp16_pkg.sv | 18 +
 rtl/fp16_normalize.sv | 23 ++
 rtl/mulhalfprecision_iter.sv | 100 ++++++++++
 tb/tb_mulhalfprecision_iter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: shared half-precision field helpers, constants and FSM encoding
package fp16_pkg;
  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam int BIAS   = 15;
  localparam logic [15:0] FP16_ZERO       = 16'h0000;
  localparam logic [14:0] FP16_MAX_FINITE = 15'h7BFF;
  typedef enum logic [2:0] {S_IDLE, S_ZERO, S_MUL, S_NORM, S_DONE} state_t;
  function automatic logic fp_sign(input logic [15:0] x);
    return x[15];
  endfunction
  function automatic logic [EXP_W-1:0] fp_exp(input logic [15:0] x);
    return x[14:10];
  endfunction
  function automatic logic [MANT_W-1:0] fp_mant(input logic [15:0] x);
    return x[9:0];
  endfunction
endpackage

// File: rtl/fp16_normalize.sv
// fp16_normalize: exponent adjust, saturate/flush and packing of a raw significand product
module fp16_normalize
  import fp16_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [6:0] exp_sum_i,
  input  logic [11:0]       p_i,
  output logic [15:0]       product_o,
  output logic              overflow_o,
  output logic              underflow_o
);
  logic signed [6:0] bias_s;
  logic signed [6:0] e;
  logic [MANT_W-1:0] m;
  assign bias_s      = 7'(BIAS);
  // p_i is the top 12 bits of a product in [2^20, 2^22); the MSB selects the binade
  assign e           = exp_sum_i - bias_s + (p_i[11] ? 7'sd1 : 7'sd0);
  assign m           = p_i[11] ? p_i[10:1] : p_i[9:0];
  assign overflow_o  = e >= 7'sd31;
  assign underflow_o = !overflow_o && e <= 7'sd0;
  assign product_o   = overflow_o ? {sign_i, FP16_MAX_FINITE} :
                       underflow_o ? FP16_ZERO : {sign_i, e[EXP_W-1:0], m};
endmodule

// File: rtl/mulhalfprecision_iter.sv
// mulhalfprecision_iter: multi-cycle fp16 multiplier, LSB-first shift-add significand product
module mulhalfprecision_iter
  import fp16_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Start,
  input  logic [15:0] i_Multiplicand,
  input  logic [15:0] i_Multiplier,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [15:0] o_Product,
  output logic        o_Overflow,
  output logic        o_Underflow
);
  state_t            state_q;
  logic              sign_q;
  logic signed [6:0] exp_sum_q;
  logic [21:0]       a_q;
  logic [21:0]       acc_q;
  logic [10:0]       b_q;
  logic [3:0]        cnt_q;
  logic              busy_q, done_q, ovf_q, unf_q;
  logic [15:0]       product_q;
  logic [15:0]       norm_p;
  logic              norm_o, norm_u;
  logic              zero_op;
  assign zero_op = fp_exp(i_Multiplicand) == '0 || fp_exp(i_Multiplier) == '0;
  fp16_normalize u_norm (
    .sign_i      (sign_q),
    .exp_sum_i   (exp_sum_q),
    .p_i         (acc_q[21:10]),
    .product_o   (norm_p),
    .overflow_o  (norm_o),
    .underflow_o (norm_u)
  );
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      exp_sum_q <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= FP16_ZERO;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // the o_Done cycle still sits in IDLE, so a start there is refused
          if (i_Start && !done_q) begin
            sign_q    <= fp_sign(i_Multiplicand) ^ fp_sign(i_Multiplier);
            exp_sum_q <= 7'(fp_exp(i_Multiplicand)) + 7'(fp_exp(i_Multiplier));
            a_q       <= {11'b0, 1'b1, fp_mant(i_Multiplicand)};
            b_q       <= {1'b1, fp_mant(i_Multiplier)};
            acc_q     <= '0;
            cnt_q     <= 4'd10;
            busy_q    <= 1'b1;
            state_q   <= zero_op ? S_ZERO : S_MUL;
          end
        end
        S_MUL: begin
          acc_q   <= b_q[0] ? acc_q + a_q : acc_q;
          a_q     <= a_q << 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q - 4'd1;
          state_q <= cnt_q == 4'd0 ? S_NORM : S_MUL;
        end
        S_NORM: begin
          product_q <= norm_p;
          ovf_q     <= norm_o;
          unf_q     <= norm_u;
          state_q   <= S_DONE;
        end
        S_ZERO: begin
          product_q <= FP16_ZERO;
          ovf_q     <= 1'b0;
          unf_q     <= 1'b0;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Product   = product_q;
  assign o_Overflow  = ovf_q;
  assign o_Underflow = unf_q;
endmodule

// File: tb/tb_mulhalfprecision_iter.sv
// tb_mulhalfprecision_iter: directed fp16 multiply vectors checked through a result scoreboard
module tb_mulhalfprecision_iter;
  logic        clk = 1'b0;
  logic        i_Reset, i_Start;
  logic [15:0] i_Multiplicand, i_Multiplier;
  logic        o_Busy, o_Done, o_Overflow, o_Underflow;
  logic [15:0] o_Product;
  int          cyc = 0;
  int          tests = 0;
  int          failed = 0;
  int          busy_cnt = 0;
  typedef struct {
    logic [15:0] p;
    logic        o;
    logic        u;
    int          cyc;
    int          busy;
  } exp_t;
  exp_t sb[$];

  mulhalfprecision_iter dut (
    .i_Clock        (clk),
    .i_Reset        (i_Reset),
    .i_Start        (i_Start),
    .i_Multiplicand (i_Multiplicand),
    .i_Multiplier   (i_Multiplier),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done),
    .o_Product      (o_Product),
    .o_Overflow     (o_Overflow),
    .o_Underflow    (o_Underflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (i_Reset) busy_cnt = 0;
    else if (o_Done) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: got product %0h with no pending result", o_Product);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("product", o_Product, e.p);
        chk("overflow", o_Overflow, e.o);
        chk("underflow", o_Underflow, e.u);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_cycles", busy_cnt, e.busy);
      end
      busy_cnt = 0;
    end else if (o_Busy) busy_cnt++;
  end

  task automatic wait_done();
    int n = 0;
    while (!o_Done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_seen", o_Done, 1);
    @(posedge clk);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] p,
                       input logic o, input logic u, input logic zp, input logic glitch);
    exp_t e;
    @(negedge clk);
    i_Start = 1'b1;
    i_Multiplicand = a;
    i_Multiplier = b;
    e.p = p;
    e.o = o;
    e.u = u;
    e.cyc = cyc + 1 + (zp ? 2 : 13);
    e.busy = zp ? 2 : 13;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_Start = 1'b0;
    i_Multiplicand = 16'h5555;
    i_Multiplier = 16'h5555;
    if (glitch) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      i_Start = 1'b1;
      i_Multiplicand = 16'h4000;
      i_Multiplier = 16'h4000;
      @(posedge clk);
      #1;
      i_Start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    i_Reset = 1'b1;
    i_Start = 1'b0;
    i_Multiplicand = '0;
    i_Multiplier = '0;
    repeat (2) @(posedge clk);
    #1;
    i_Reset = 1'b0;
    chk("rst_busy", o_Busy, 0);
    chk("rst_done", o_Done, 0);
    chk("rst_product", o_Product, 16'h0000);
    chk("rst_flags", {o_Overflow, o_Underflow}, 0);
    do_op(16'h3C00, 16'h3C00, 16'h3C00, 0, 0, 0, 0);
    do_op(16'h4000, 16'hC200, 16'hC600, 0, 0, 0, 0);
    do_op(16'h3E00, 16'h3E00, 16'h4080, 0, 0, 0, 0);
    do_op(16'h7800, 16'h4000, 16'h7BFF, 1, 0, 0, 0);
    do_op(16'h0400, 16'h3800, 16'h0000, 0, 1, 0, 0);
    do_op(16'h3E00, 16'h3E00, 16'h4080, 0, 0, 0, 0);
    do_op(16'h0000, 16'h4500, 16'h0000, 0, 0, 1, 0);
    do_op(16'hC200, 16'h3C00, 16'hC200, 0, 0, 0, 0);
    do_op(16'hC500, 16'h8000, 16'h0000, 0, 0, 1, 0);
    do_op(16'h3E00, 16'h3C00, 16'h3E00, 0, 0, 0, 1);
    // abort: reset sampled at the fifth edge after the start edge
    @(negedge clk);
    i_Start = 1'b1;
    i_Multiplicand = 16'h3C00;
    i_Multiplier = 16'h3C00;
    @(posedge clk);
    #1;
    i_Start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    i_Reset = 1'b1;
    @(posedge clk);
    #1;
    i_Reset = 1'b0;
    chk("abort_busy", o_Busy, 0);
    chk("abort_done", o_Done, 0);
    chk("abort_product", o_Product, 16'h0000);
    chk("abort_flags", {o_Overflow, o_Underflow}, 0);
    repeat (20) @(posedge clk);
    do_op(16'h4000, 16'h4000, 16'h4400, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("held_product", o_Product, 16'h4400);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
